// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounces raw set/clear request lines and issues mutually
// exclusive, registered s/r pulses toward the SR latch stage, with a
// programmable idle gap after every pulse. Clear wins over set.
module sr_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4,  // stable cycles to accept a level change (1..255)
  parameter int unsigned GAP_CYCLES = 2   // idle cycles after each pulse (0..15)
) (
  input  logic clk,
  input  logic rst,       // synchronous, active-low
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic conflict,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int unsigned CH_SET = 0;
  localparam int unsigned CH_CLR = 1;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  // Per-channel vectors: bit CH_SET is the set channel, bit CH_CLR the clear channel.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      deb_dly_q, deb_dly_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      pend_q, pend_d;
  state_t          state_q, state_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            conflict_q, conflict_d;
  logic            busy_q, busy_d;

  logic [1:0] rise;
  logic       take_set;
  logic       take_clr;

  // Synchronizers and debounce counters: a level change is accepted once the
  // synchronized input has disagreed with the debounced level for DEB_CYCLES
  // consecutive cycles; any agreement restarts the count.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned and no latch is inferred.
    sync1_d   = {clr_in, set_in};
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != deb_q[ch]) begin
        if (cnt_q[ch] + 8'd1 == DEB_LAST) begin
          deb_d[ch] = ~deb_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 8'd1;
        end
      end
    end
    rise = deb_q & ~deb_dly_q;
  end

  // Pulse FSM next state, pending-request bookkeeping and registered outputs.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    take_set  = 1'b0;
    take_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_q[CH_CLR]) begin
          state_d  = CLR_P;
          take_clr = 1'b1;
        end else if (pend_q[CH_SET]) begin
          state_d  = SET_P;
          take_set = 1'b1;
        end
      end
      SET_P, CLR_P: begin
        gap_cnt_d = 4'd0;
        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A set that rises together with a clear is discarded in favour of the clear.
    pend_d[CH_CLR] = (pend_q[CH_CLR] & ~take_clr) | rise[CH_CLR];
    pend_d[CH_SET] = (pend_q[CH_SET] & ~take_set) | (rise[CH_SET] & ~rise[CH_CLR]);
    conflict_d     = rise[CH_SET] & rise[CH_CLR];

    // Outputs are decoded from the next state so they leave flops aligned with it.
    s_d    = (state_d == SET_P);
    r_d    = (state_d == CLR_P);
    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      busy_q     <= busy_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: two instances (default parameters, and DEB_CYCLES=1 /
// GAP_CYCLES=0) driven by the same inputs, each compared every cycle against
// a behavioural model, plus directed scenarios with hand-derived expectations.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst, set_in, clr_in;
  logic s_a, r_a, conf_a, busy_a;
  logic s_b, r_b, conf_b, busy_b;

  always #5 clk = ~clk;

  sr_cmd_gen dut_a (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
    .s(s_a), .r(r_a), .conflict(conf_a), .busy(busy_a)
  );

  sr_cmd_gen #(.DEB_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_in(clr_in),
    .s(s_b), .r(r_b), .conflict(conf_b), .busy(busy_b)
  );

  // Behavioural model: state after a clock edge. Index 0 = set, 1 = clear.
  typedef struct {
    bit [1:0]      raw1;       // raw sampled one edge ago
    bit [1:0]      raw2;       // raw sampled two edges ago (synchronized view)
    bit [1:0]      lvl;        // accepted (debounced) level
    bit [1:0]      lvl_prev;   // accepted level one edge earlier
    bit [1:0][8:0] run;        // consecutive disagreeing cycles
    bit            ps, pc;     // pending set / clear
    bit            s, r, conflict;
    int            busy_left;  // non-idle cycles remaining, including this one
  } mdl_t;

  function automatic mdl_t step(mdl_t o, bit rs, bit rc, bit rst_n, int deb, int gap);
    mdl_t     n;
    bit [1:0] rise;
    bit       idle, take_c, take_s;
    n = o;
    if (!rst_n) begin
      n = '{default: '0};
      return n;
    end
    n.raw1 = {rc, rs};
    n.raw2 = o.raw1;
    for (int ch = 0; ch < 2; ch++) begin
      if (o.raw2[ch] != o.lvl[ch]) begin
        if (int'(o.run[ch]) + 1 == deb) begin
          n.lvl[ch] = ~o.lvl[ch];
          n.run[ch] = '0;
        end else begin
          n.run[ch] = 9'(int'(o.run[ch]) + 1);
        end
      end else begin
        n.run[ch] = '0;
      end
    end
    rise       = o.lvl & ~o.lvl_prev;
    n.lvl_prev = o.lvl;
    idle       = (o.busy_left == 0);
    take_c     = idle && o.pc;
    take_s     = idle && !o.pc && o.ps;
    n.s        = take_s;
    n.r        = take_c;
    n.busy_left = (take_c || take_s) ? 1 + gap : (o.busy_left > 0 ? o.busy_left - 1 : 0);
    n.pc       = (o.pc && !take_c) || rise[1];
    n.ps       = (o.ps && !take_s) || (rise[0] && !rise[1]);
    n.conflict = rise[0] && rise[1];
    return n;
  endfunction

  mdl_t m_a = '{default: '0};
  mdl_t m_b = '{default: '0};
  int   cyc = 0;
  bit   chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model advances on the same edges as the DUTs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_a <= step(m_a, set_in, clr_in, rst, 4, 2);
    m_b <= step(m_b, set_in, clr_in, rst, 1, 0);
  end

  // Pulse statistics used by the directed scenarios.
  int tot_sa = 0, tot_ra = 0, tot_ca = 0, tot_ba = 0;
  int tot_sb = 0, tot_rb = 0, order_err_b = 0;
  int s_cyc_a = 0, r_cyc_a = 0;
  int last_b = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_s",        s_a,    m_a.s);
      check("a_r",        r_a,    m_a.r);
      check("a_conflict", conf_a, m_a.conflict);
      check("a_busy",     busy_a, m_a.busy_left != 0);
      check("a_excl",     s_a & r_a, 0);
      check("b_s",        s_b,    m_b.s);
      check("b_r",        r_b,    m_b.r);
      check("b_conflict", conf_b, m_b.conflict);
      check("b_busy",     busy_b, m_b.busy_left != 0);
      check("b_excl",     s_b & r_b, 0);
      if (s_a)    begin tot_sa <= tot_sa + 1; s_cyc_a <= cyc; end
      if (r_a)    begin tot_ra <= tot_ra + 1; r_cyc_a <= cyc; end
      if (conf_a) tot_ca <= tot_ca + 1;
      if (busy_a) tot_ba <= tot_ba + 1;
      if (s_b) begin
        tot_sb <= tot_sb + 1;
        if (last_b == 1) order_err_b <= order_err_b + 1;
        last_b <= 1;
      end
      if (r_b) begin
        tot_rb <= tot_rb + 1;
        if (last_b == 2) order_err_b <= order_err_b + 1;
        last_b <= 2;
      end
    end
  end

  task automatic drive(input bit vs, input bit vc, input int n);
    @(negedge clk);
    set_in = vs;
    clr_in = vc;
    repeat (n - 1) @(negedge clk);
  endtask

  int sa0, ra0, ca0, ba0, sb0, rb0, oe0, e0;

  initial begin
    rst = 1'b0; set_in = 1'b0; clr_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_s",    s_a,    0);
    check("reset_r",    r_a,    0);
    check("reset_busy", busy_a, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Clean set rising edge: single s pulse at E0+7, busy for 1+GAP cycles.
    sa0 = tot_sa; ra0 = tot_ra; ba0 = tot_ba;
    set_in = 1'b1;
    e0 = cyc + 1;
    repeat (15) @(negedge clk);
    check("req027_s_count",  tot_sa - sa0, 1);
    check("req027_s_cycle",  s_cyc_a, e0 + 7);
    check("req027_r_count",  tot_ra - ra0, 0);
    check("req027_busy_len", tot_ba - ba0, 3);
    sa0 = tot_sa;
    drive(1'b0, 1'b0, 20);
    check("fall_no_pulse", tot_sa - sa0, 0);

    // Short bounce below the debounce length.
    sa0 = tot_sa; ba0 = tot_ba;
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 15);
    check("req028_s_count", tot_sa - sa0, 0);
    check("req028_busy",    tot_ba - ba0, 0);

    // Simultaneous rise: clear wins, conflict flagged once.
    sa0 = tot_sa; ra0 = tot_ra; ca0 = tot_ca;
    drive(1'b1, 1'b1, 15);
    check("req029_r_count",    tot_ra - ra0, 1);
    check("req029_s_count",    tot_sa - sa0, 0);
    check("req029_conflict",   tot_ca - ca0, 1);
    drive(1'b0, 1'b0, 20);

    // Clear one cycle behind set: s first, r after the gap.
    sa0 = tot_sa; ra0 = tot_ra;
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 25);
    check("req030_s_count", tot_sa - sa0, 1);
    check("req030_r_count", tot_ra - ra0, 1);
    check("req030_order",   (r_cyc_a - s_cyc_a) > 2, 1);
    drive(1'b0, 1'b0, 20);

    // Reset during the set pulse with a clear pending.
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 1);
    for (int i = 0; i < 30 && !s_a; i++) @(negedge clk);
    check("req031_s_seen", s_a, 1);
    rst = 1'b0; set_in = 1'b0; clr_in = 1'b0;
    @(negedge clk);
    check("req031_s_after",    s_a,    0);
    check("req031_r_after",    r_a,    0);
    check("req031_busy_after", busy_a, 0);
    rst = 1'b1;
    sa0 = tot_sa; ra0 = tot_ra;
    repeat (20) @(negedge clk);
    check("req031_no_s", tot_sa - sa0, 0);
    check("req031_no_r", tot_ra - ra0, 0);

    // Fast instance: alternate set/clear every 6 cycles.
    sb0 = tot_sb; rb0 = tot_rb; oe0 = order_err_b;
    for (int i = 0; i < 10; i++) drive(i % 2 == 0, i % 2 == 1, 6);
    drive(1'b0, 1'b0, 10);
    check("req032_s_count", tot_sb - sb0, 5);
    check("req032_r_count", tot_rb - rb0, 5);
    check("req032_order",   order_err_b - oe0, 0);

    // Randomized stretches, bounces, simultaneous edges and occasional resets.
    for (int seg = 0; seg < 1500; seg++) begin
      bit vs, vc;
      int dur;
      vs  = 1'($urandom_range(0, 1));
      vc  = ($urandom_range(0, 3) == 0) ? vs : 1'($urandom_range(0, 1));
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        rst = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        rst = 1'b1;
      end
      drive(vs, vc, dur);
    end
    drive(1'b0, 1'b0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
